// File: rtl/err_stat_acc.sv
// -----------------------------------------------------------------------------
// err_stat_acc
//   Accumulates error statistics between an approximate 8x8 multiplier product
//   and its exact reference over a run of N_SAMPLES product pairs.
//
//   Each accepted pair goes through a two-stage pipeline:
//     stage 1 registers ed = |approx_p - exact_p| and ne = (ed != 0)
//     stage 2 folds them into sample_cnt, err_cnt, sum_ed and max_ed
//   The FSM (IDLE -> RUN -> DRAIN -> DONE) stops accepting after N_SAMPLES
//   pairs, waits two cycles in DRAIN for the pipeline to empty, then raises
//   done with the statistics frozen.
//
// Handshake: a pair transfers on a rising CLK edge where in_valid && in_ready.
//   in_ready is high only in RUN; in_valid may drop at any time (bubble).
//
// Parameters
//   N_SAMPLES   pairs per run, 1..65536
//
// Ports
//   CLK, RST_N  clock (rising edge), asynchronous active-low reset
//   start       one-cycle pulse: clear statistics and begin a run (IDLE/DONE)
//   in_valid    product pair valid
//   in_ready    block accepts a pair this cycle
//   approx_p    approximate product (unsigned 16 bit)
//   exact_p     exact product (unsigned 16 bit)
//   busy        RUN or DRAIN
//   done        DONE; statistics final and stable
//   sample_cnt  accumulated pairs
//   err_cnt     pairs with approx_p != exact_p
//   sum_ed      sum of |approx_p - exact_p|
//   max_ed      largest |approx_p - exact_p|
//   sum_sed     (ERR_SIGNED_SUM_EN only) signed sum of approx_p - exact_p
//   fsm_state   debug view of the FSM: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE
//
// Optional feature macro: ERR_SIGNED_SUM_EN adds sum_sed and its pipeline.
// -----------------------------------------------------------------------------
module err_stat_acc #(
    parameter int N_SAMPLES = 65536
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        approx_p,
    input  logic [15:0]        exact_p,
    output logic               busy,
    output logic               done,
    output logic [16:0]        sample_cnt,
    output logic [16:0]        err_cnt,
    output logic [31:0]        sum_ed,
    output logic [15:0]        max_ed,
`ifdef ERR_SIGNED_SUM_EN
    output logic signed [32:0] sum_sed,
`endif
    output logic [1:0]         fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [16:0] LAST_IDX = 17'(N_SAMPLES - 1);

    state_t      state;
    logic [16:0] acc_cnt;    // pairs accepted so far in this run
    logic        drain_cnt;  // cycles spent in DRAIN
    logic        accept;
    logic        start_ok;

    // Stage-1 pipeline registers
    logic        v1;
    logic [15:0] ed1;
    logic        ne1;
    logic [15:0] ed_c;

    assign accept    = in_valid && in_ready;
    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign fsm_state = state;

    // Absolute difference without wrap: subtract the smaller from the larger.
    always_comb begin
        ed_c = 16'd0;
        if (approx_p >= exact_p) ed_c = approx_p - exact_p;
        else                     ed_c = exact_p - approx_p;
    end

    // Control FSM; in_ready/busy/done are registered alongside the state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            acc_cnt   <= 17'd0;
            drain_cnt <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        acc_cnt  <= 17'd0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (acc_cnt == LAST_IDX) begin
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            drain_cnt <= 1'b0;
                        end else begin
                            acc_cnt <= acc_cnt + 17'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ERR_SIGNED_SUM_EN
    logic [16:0] sd_c;
    logic [16:0] sd1;
    // 17-bit modular subtraction of zero-extended operands is the exact
    // two's complement difference.
    assign sd_c = {1'b0, approx_p} - {1'b0, exact_p};
`endif

    // Stage 1: register the per-pair error terms.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            v1  <= 1'b0;
            ed1 <= 16'd0;
            ne1 <= 1'b0;
`ifdef ERR_SIGNED_SUM_EN
            sd1 <= 17'd0;
`endif
        end else begin
            v1 <= accept;
            if (accept) begin
                ed1 <= ed_c;
                ne1 <= (ed_c != 16'd0);
`ifdef ERR_SIGNED_SUM_EN
                sd1 <= sd_c;
`endif
            end
        end
    end

    // Stage 2: accumulate. Bubbles (v1 == 0) leave statistics untouched.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sample_cnt <= 17'd0;
            err_cnt    <= 17'd0;
            sum_ed     <= 32'd0;
            max_ed     <= 16'd0;
`ifdef ERR_SIGNED_SUM_EN
            sum_sed    <= 33'sd0;
`endif
        end else if (start_ok) begin
            sample_cnt <= 17'd0;
            err_cnt    <= 17'd0;
            sum_ed     <= 32'd0;
            max_ed     <= 16'd0;
`ifdef ERR_SIGNED_SUM_EN
            sum_sed    <= 33'sd0;
`endif
        end else if (v1) begin
            sample_cnt <= sample_cnt + 17'd1;
            err_cnt    <= err_cnt + {16'd0, ne1};
            sum_ed     <= sum_ed + {16'd0, ed1};
            if (ed1 > max_ed) max_ed <= ed1;
`ifdef ERR_SIGNED_SUM_EN
            sum_sed    <= sum_sed + {{16{sd1[16]}}, sd1};
`endif
        end
    end

endmodule

// File: tb/tb_err_stat_acc.sv
// -----------------------------------------------------------------------------
// tb_err_stat_acc
//   Directed bench for err_stat_acc. Four instances with N_SAMPLES = 4, 3, 1
//   and 65536 share clock, reset and data inputs; each has its own start and
//   in_valid so only one is exercised at a time. Scenario tasks drive stimulus
//   and compare against hand-computed values. Handshake: a pair transfers on a
//   rising edge with in_valid && in_ready; inputs are changed 1 ns after an
//   edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_err_stat_acc;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic        clk;
    logic        rst_n;
    logic [15:0] approx_p;
    logic [15:0] exact_p;
    logic        start_v      [4];
    logic        in_valid_v   [4];
    logic        in_ready_v   [4];
    logic        busy_v       [4];
    logic        done_v       [4];
    logic [16:0] sample_cnt_v [4];
    logic [16:0] err_cnt_v    [4];
    logic [31:0] sum_ed_v     [4];
    logic [15:0] max_ed_v     [4];
    logic [1:0]  fsm_state_v  [4];
`ifdef ERR_SIGNED_SUM_EN
    logic signed [32:0] sum_sed_v [4];
`endif

    int n_cmp;
    int n_bad;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int NS = (g == 0) ? 4 : (g == 1) ? 3 : (g == 2) ? 1 : 65536;
        err_stat_acc #(.N_SAMPLES(NS)) u_dut (
            .CLK        (clk),
            .RST_N      (rst_n),
            .start      (start_v[g]),
            .in_valid   (in_valid_v[g]),
            .in_ready   (in_ready_v[g]),
            .approx_p   (approx_p),
            .exact_p    (exact_p),
            .busy       (busy_v[g]),
            .done       (done_v[g]),
            .sample_cnt (sample_cnt_v[g]),
            .err_cnt    (err_cnt_v[g]),
            .sum_ed     (sum_ed_v[g]),
            .max_ed     (max_ed_v[g]),
`ifdef ERR_SIGNED_SUM_EN
            .sum_sed    (sum_sed_v[g]),
`endif
            .fsm_state  (fsm_state_v[g])
        );
    end

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int i);
        start_v[i] = 1'b1;
        tick();
        start_v[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (in_ready_v[i] !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready[%0d]: got %b want 0", i, in_ready_v[i]); end
            n_cmp++; if (busy_v[i] !== 1'b0) begin n_bad++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy_v[i]); end
            n_cmp++; if (done_v[i] !== 1'b0) begin n_bad++; $display("FAIL reset_done[%0d]: got %b want 0", i, done_v[i]); end
            n_cmp++; if (sample_cnt_v[i] !== 17'd0) begin n_bad++; $display("FAIL reset_sample_cnt[%0d]: got %0d want 0", i, sample_cnt_v[i]); end
            n_cmp++; if (fsm_state_v[i] !== S_IDLE) begin n_bad++; $display("FAIL reset_state[%0d]: got %0d want 0", i, fsm_state_v[i]); end
        end
        n_cmp++; if (err_cnt_v[0] !== 17'd0) begin n_bad++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt_v[0]); end
        n_cmp++; if (sum_ed_v[0] !== 32'd0) begin n_bad++; $display("FAIL reset_sum_ed: got %0d want 0", sum_ed_v[0]); end
        n_cmp++; if (max_ed_v[0] !== 16'd0) begin n_bad++; $display("FAIL reset_max_ed: got %0d want 0", max_ed_v[0]); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // N=4, pairs back to back: ed 0,10,50,0 -> sum 60, max 50, 2 errors,
    // signed sum 0-10+50+0 = 40.
    task automatic test_basic();
        logic [15:0] va [4];
        logic [15:0] ve [4];
        va = '{16'd100, 16'd90, 16'd300, 16'd0};
        ve = '{16'd100, 16'd100, 16'd250, 16'd0};
        do_start(0);
        n_cmp++; if (in_ready_v[0] !== 1'b1) begin n_bad++; $display("FAIL basic_ready_after_start: got %b want 1", in_ready_v[0]); end
        n_cmp++; if (busy_v[0] !== 1'b1) begin n_bad++; $display("FAIL basic_busy_after_start: got %b want 1", busy_v[0]); end
        n_cmp++; if (fsm_state_v[0] !== S_RUN) begin n_bad++; $display("FAIL basic_state_run: got %0d want 1", fsm_state_v[0]); end
        for (int k = 0; k < 4; k++) begin
            approx_p = va[k];
            exact_p  = ve[k];
            in_valid_v[0] = 1'b1;
            tick();
        end
        in_valid_v[0] = 1'b0;
        n_cmp++; if (in_ready_v[0] !== 1'b0) begin n_bad++; $display("FAIL basic_ready_after_last: got %b want 0", in_ready_v[0]); end
        n_cmp++; if (fsm_state_v[0] !== S_DRAIN) begin n_bad++; $display("FAIL basic_state_drain: got %0d want 2", fsm_state_v[0]); end
        tick();
        n_cmp++; if (done_v[0] !== 1'b0) begin n_bad++; $display("FAIL basic_done_early: got %b want 0", done_v[0]); end
        n_cmp++; if (busy_v[0] !== 1'b1) begin n_bad++; $display("FAIL basic_busy_drain: got %b want 1", busy_v[0]); end
        tick();
        n_cmp++; if (done_v[0] !== 1'b1) begin n_bad++; $display("FAIL basic_done: got %b want 1", done_v[0]); end
        n_cmp++; if (busy_v[0] !== 1'b0) begin n_bad++; $display("FAIL basic_busy_done: got %b want 0", busy_v[0]); end
        n_cmp++; if (sample_cnt_v[0] !== 17'd4) begin n_bad++; $display("FAIL basic_sample_cnt: got %0d want 4", sample_cnt_v[0]); end
        n_cmp++; if (err_cnt_v[0] !== 17'd2) begin n_bad++; $display("FAIL basic_err_cnt: got %0d want 2", err_cnt_v[0]); end
        n_cmp++; if (sum_ed_v[0] !== 32'd60) begin n_bad++; $display("FAIL basic_sum_ed: got %0d want 60", sum_ed_v[0]); end
        n_cmp++; if (max_ed_v[0] !== 16'd50) begin n_bad++; $display("FAIL basic_max_ed: got %0d want 50", max_ed_v[0]); end
`ifdef ERR_SIGNED_SUM_EN
        n_cmp++; if (sum_sed_v[0] !== 33'sd40) begin n_bad++; $display("FAIL basic_sum_sed: got %0d want 40", sum_sed_v[0]); end
`endif
    endtask

    // N=3, valid 1,0,1,0,1 with (10,7): ed 3 each -> sum 9, 3 errors.
    task automatic test_bubbles();
        logic pat [5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        approx_p = 16'd10;
        exact_p  = 16'd7;
        do_start(1);
        for (int k = 0; k < 5; k++) begin
            in_valid_v[1] = pat[k];
            tick();
            if (k == 1) begin
                n_cmp++; if (in_ready_v[1] !== 1'b1) begin n_bad++; $display("FAIL bubble_ready_gap: got %b want 1", in_ready_v[1]); end
            end
            if (k == 2) begin
                n_cmp++; if (in_ready_v[1] !== 1'b1) begin n_bad++; $display("FAIL bubble_ready_2nd: got %b want 1", in_ready_v[1]); end
            end
        end
        in_valid_v[1] = 1'b0;
        n_cmp++; if (in_ready_v[1] !== 1'b0) begin n_bad++; $display("FAIL bubble_ready_3rd: got %b want 0", in_ready_v[1]); end
        tick();
        tick();
        n_cmp++; if (done_v[1] !== 1'b1) begin n_bad++; $display("FAIL bubble_done: got %b want 1", done_v[1]); end
        n_cmp++; if (sample_cnt_v[1] !== 17'd3) begin n_bad++; $display("FAIL bubble_sample_cnt: got %0d want 3", sample_cnt_v[1]); end
        n_cmp++; if (err_cnt_v[1] !== 17'd3) begin n_bad++; $display("FAIL bubble_err_cnt: got %0d want 3", err_cnt_v[1]); end
        n_cmp++; if (sum_ed_v[1] !== 32'd9) begin n_bad++; $display("FAIL bubble_sum_ed: got %0d want 9", sum_ed_v[1]); end
        n_cmp++; if (max_ed_v[1] !== 16'd3) begin n_bad++; $display("FAIL bubble_max_ed: got %0d want 3", max_ed_v[1]); end
`ifdef ERR_SIGNED_SUM_EN
        n_cmp++; if (sum_sed_v[1] !== 33'sd9) begin n_bad++; $display("FAIL bubble_sum_sed: got %0d want 9", sum_sed_v[1]); end
`endif
        // Valid held high in DONE must not change anything.
        in_valid_v[1] = 1'b1;
        tick();
        tick();
        tick();
        in_valid_v[1] = 1'b0;
        n_cmp++; if (sample_cnt_v[1] !== 17'd3) begin n_bad++; $display("FAIL bubble_hold_sample_cnt: got %0d want 3", sample_cnt_v[1]); end
        n_cmp++; if (sum_ed_v[1] !== 32'd9) begin n_bad++; $display("FAIL bubble_hold_sum_ed: got %0d want 9", sum_ed_v[1]); end
        n_cmp++; if (done_v[1] !== 1'b1) begin n_bad++; $display("FAIL bubble_hold_done: got %b want 1", done_v[1]); end
    endtask

    // N=4, four (20,10) pairs with a start pulse on the third accept cycle.
    task automatic test_start_ignored();
        approx_p = 16'd20;
        exact_p  = 16'd10;
        do_start(0);
        in_valid_v[0] = 1'b1;
        tick();
        tick();
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        n_cmp++; if (fsm_state_v[0] !== S_RUN) begin n_bad++; $display("FAIL ign_state_run: got %0d want 1", fsm_state_v[0]); end
        n_cmp++; if (sample_cnt_v[0] !== 17'd2) begin n_bad++; $display("FAIL ign_sample_cnt_mid: got %0d want 2", sample_cnt_v[0]); end
        tick();
        in_valid_v[0] = 1'b0;
        n_cmp++; if (fsm_state_v[0] !== S_DRAIN) begin n_bad++; $display("FAIL ign_state_drain: got %0d want 2", fsm_state_v[0]); end
        tick();
        tick();
        n_cmp++; if (done_v[0] !== 1'b1) begin n_bad++; $display("FAIL ign_done: got %b want 1", done_v[0]); end
        n_cmp++; if (sample_cnt_v[0] !== 17'd4) begin n_bad++; $display("FAIL ign_sample_cnt: got %0d want 4", sample_cnt_v[0]); end
        n_cmp++; if (err_cnt_v[0] !== 17'd4) begin n_bad++; $display("FAIL ign_err_cnt: got %0d want 4", err_cnt_v[0]); end
        n_cmp++; if (sum_ed_v[0] !== 32'd40) begin n_bad++; $display("FAIL ign_sum_ed: got %0d want 40", sum_ed_v[0]); end
        n_cmp++; if (max_ed_v[0] !== 16'd10) begin n_bad++; $display("FAIL ign_max_ed: got %0d want 10", max_ed_v[0]); end
    endtask

    // Start from DONE clears every statistic on the same edge.
    task automatic test_restart();
        do_start(0);
        n_cmp++; if (sample_cnt_v[0] !== 17'd0) begin n_bad++; $display("FAIL restart_sample_cnt: got %0d want 0", sample_cnt_v[0]); end
        n_cmp++; if (err_cnt_v[0] !== 17'd0) begin n_bad++; $display("FAIL restart_err_cnt: got %0d want 0", err_cnt_v[0]); end
        n_cmp++; if (sum_ed_v[0] !== 32'd0) begin n_bad++; $display("FAIL restart_sum_ed: got %0d want 0", sum_ed_v[0]); end
        n_cmp++; if (max_ed_v[0] !== 16'd0) begin n_bad++; $display("FAIL restart_max_ed: got %0d want 0", max_ed_v[0]); end
`ifdef ERR_SIGNED_SUM_EN
        n_cmp++; if (sum_sed_v[0] !== 33'sd0) begin n_bad++; $display("FAIL restart_sum_sed: got %0d want 0", sum_sed_v[0]); end
`endif
        n_cmp++; if (busy_v[0] !== 1'b1) begin n_bad++; $display("FAIL restart_busy: got %b want 1", busy_v[0]); end
        n_cmp++; if (done_v[0] !== 1'b0) begin n_bad++; $display("FAIL restart_done: got %b want 0", done_v[0]); end
        n_cmp++; if (in_ready_v[0] !== 1'b1) begin n_bad++; $display("FAIL restart_ready: got %b want 1", in_ready_v[0]); end
    endtask

    // Reset one cycle after an accept: outputs clear without a clock edge,
    // and nothing moves after release until a new start.
    task automatic test_reset_midrun();
        approx_p = 16'd200;
        exact_p  = 16'd100;
        in_valid_v[0] = 1'b1;
        tick();
        in_valid_v[0] = 1'b0;
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (fsm_state_v[0] !== S_IDLE) begin n_bad++; $display("FAIL rstmid_state: got %0d want 0", fsm_state_v[0]); end
        n_cmp++; if (in_ready_v[0] !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready: got %b want 0", in_ready_v[0]); end
        n_cmp++; if (busy_v[0] !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy_v[0]); end
        n_cmp++; if (sample_cnt_v[0] !== 17'd0) begin n_bad++; $display("FAIL rstmid_sample_cnt: got %0d want 0", sample_cnt_v[0]); end
        n_cmp++; if (sum_ed_v[0] !== 32'd0) begin n_bad++; $display("FAIL rstmid_sum_ed: got %0d want 0", sum_ed_v[0]); end
        n_cmp++; if (max_ed_v[0] !== 16'd0) begin n_bad++; $display("FAIL rstmid_max_ed: got %0d want 0", max_ed_v[0]); end
        #1;
        rst_n = 1'b1;
        in_valid_v[0] = 1'b1;
        tick();
        tick();
        tick();
        in_valid_v[0] = 1'b0;
        n_cmp++; if (in_ready_v[0] !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready_after: got %b want 0", in_ready_v[0]); end
        n_cmp++; if (sample_cnt_v[0] !== 17'd0) begin n_bad++; $display("FAIL rstmid_sample_after: got %0d want 0", sample_cnt_v[0]); end
        n_cmp++; if (sum_ed_v[0] !== 32'd0) begin n_bad++; $display("FAIL rstmid_sum_after: got %0d want 0", sum_ed_v[0]); end
        n_cmp++; if (fsm_state_v[0] !== S_IDLE) begin n_bad++; $display("FAIL rstmid_state_after: got %0d want 0", fsm_state_v[0]); end
    endtask

    // N=1, single (5,5): accept edge, two DRAIN edges, then DONE.
    task automatic test_single();
        approx_p = 16'd5;
        exact_p  = 16'd5;
        do_start(2);
        in_valid_v[2] = 1'b1;
        tick();
        in_valid_v[2] = 1'b0;
        n_cmp++; if (fsm_state_v[2] !== S_DRAIN) begin n_bad++; $display("FAIL single_state_drain: got %0d want 2", fsm_state_v[2]); end
        n_cmp++; if (done_v[2] !== 1'b0) begin n_bad++; $display("FAIL single_done_e1: got %b want 0", done_v[2]); end
        tick();
        n_cmp++; if (done_v[2] !== 1'b0) begin n_bad++; $display("FAIL single_done_e2: got %b want 0", done_v[2]); end
        tick();
        n_cmp++; if (done_v[2] !== 1'b1) begin n_bad++; $display("FAIL single_done_e3: got %b want 1", done_v[2]); end
        n_cmp++; if (sample_cnt_v[2] !== 17'd1) begin n_bad++; $display("FAIL single_sample_cnt: got %0d want 1", sample_cnt_v[2]); end
        n_cmp++; if (err_cnt_v[2] !== 17'd0) begin n_bad++; $display("FAIL single_err_cnt: got %0d want 0", err_cnt_v[2]); end
        n_cmp++; if (max_ed_v[2] !== 16'd0) begin n_bad++; $display("FAIL single_max_ed: got %0d want 0", max_ed_v[2]); end
        n_cmp++; if (sum_ed_v[2] !== 32'd0) begin n_bad++; $display("FAIL single_sum_ed: got %0d want 0", sum_ed_v[2]); end
    endtask

    // N=65536, every pair (65535,0): sum 65536*65535 = 4294901760.
    task automatic test_sweep();
        int cyc;
        approx_p = 16'd65535;
        exact_p  = 16'd0;
        do_start(3);
        in_valid_v[3] = 1'b1;
        cyc = 0;
        while (done_v[3] !== 1'b1 && cyc < 70000) begin
            tick();
            cyc++;
        end
        in_valid_v[3] = 1'b0;
        n_cmp++; if (done_v[3] !== 1'b1) begin n_bad++; $display("FAIL sweep_done_timeout: got %b want 1 after %0d cycles", done_v[3], cyc); end
        n_cmp++; if (cyc != 65538) begin n_bad++; $display("FAIL sweep_latency: got %0d want 65538", cyc); end
        n_cmp++; if (sample_cnt_v[3] !== 17'd65536) begin n_bad++; $display("FAIL sweep_sample_cnt: got %0d want 65536", sample_cnt_v[3]); end
        n_cmp++; if (err_cnt_v[3] !== 17'd65536) begin n_bad++; $display("FAIL sweep_err_cnt: got %0d want 65536", err_cnt_v[3]); end
        n_cmp++; if (sum_ed_v[3] !== 32'd4294901760) begin n_bad++; $display("FAIL sweep_sum_ed: got %0d want 4294901760", sum_ed_v[3]); end
        n_cmp++; if (max_ed_v[3] !== 16'd65535) begin n_bad++; $display("FAIL sweep_max_ed: got %0d want 65535", max_ed_v[3]); end
`ifdef ERR_SIGNED_SUM_EN
        n_cmp++; if (sum_sed_v[3] !== 33'sd4294901760) begin n_bad++; $display("FAIL sweep_sum_sed: got %0d want 4294901760", sum_sed_v[3]); end
`endif
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        approx_p = 16'd0;
        exact_p  = 16'd0;
        for (int i = 0; i < 4; i++) begin
            start_v[i]    = 1'b0;
            in_valid_v[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_bubbles();
        test_start_ignored();
        test_restart();
        test_reset_midrun();
        test_single();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
